reg_file_scoreboard: RTL

Two-read, one-write general-purpose register file with a per-register pending-write scoreboard. It consumes the read-register selects RR1/RR2 produced by the read-register select stage and the write-back port from the write-back stage. It returns registered operand values DataA/DataB to the execute stage. It raises a stall when a selected operand still awaits an outstanding load.

---
 rtl/reg_file_scoreboard_if.sv | 33 +++
 rtl/reg_file_scoreboard.sv | 80 ++++++++
 2 files changed

// File: rtl/reg_file_scoreboard_if.sv
// Operand-read, write-back and load-lock bundle between the
// pipeline control (master) and the register file (slave).
interface reg_file_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]      RR1;
    logic [ADDR_W-1:0]      RR2;
    logic                   rd_en;
    logic                   RegWrite;
    logic [ADDR_W-1:0]      WR;
    logic [DATA_W-1:0]      WD;
    logic                   lock_en;
    logic [ADDR_W-1:0]      lock_reg;
    logic [DATA_W-1:0]      DataA;
    logic [DATA_W-1:0]      DataB;
    logic                   stall;
    logic [2**ADDR_W-1:0]   pending;

    modport master (
        output RR1, RR2, rd_en,
        output RegWrite, WR, WD,
        output lock_en, lock_reg,
        input  DataA, DataB, stall, pending
    );

    modport slave (
        input  RR1, RR2, rd_en,
        input  RegWrite, WR, WD,
        input  lock_en, lock_reg,
        output DataA, DataB, stall, pending
    );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Two-read / one-write register file with write-back forwarding and a
// per-register pending-load scoreboard that stalls operand capture.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_file_scoreboard_if.slave bus
);
    localparam int N = 2**ADDR_W;

    logic [DATA_W-1:0] regs [N];
    logic [N-1:0]      pending_q;
    logic [N-1:0]      pending_nxt;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic              wb;
    logic              hit_a;
    logic              hit_b;
    logic              haz_a;
    logic              haz_b;
    logic              stall;
    logic              lock;

    assign wb    = bus.RegWrite && (bus.WR != '0);
    assign lock  = bus.lock_en && (bus.lock_reg != '0);
    assign hit_a = wb && (bus.WR == bus.RR1);
    assign hit_b = wb && (bus.WR == bus.RR2);

    // regs[0] is never written, so it reads as zero without a special case
    assign fwd_a = hit_a ? bus.WD : regs[bus.RR1];
    assign fwd_b = hit_b ? bus.WD : regs[bus.RR2];

    assign haz_a = pending_q[bus.RR1] && !hit_a;
    assign haz_b = pending_q[bus.RR2] && !hit_b;
    assign stall = bus.rd_en && (haz_a || haz_b);

    // Set is applied after clear: a fresh load outranks the completing one
    always_comb begin
        pending_nxt = pending_q;
        if (wb)
            pending_nxt[bus.WR] = 1'b0;
        if (lock)
            pending_nxt[bus.lock_reg] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                regs[i] <= '0;
        end else if (wb) begin
            regs[bus.WR] <= bus.WD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pending_q <= '0;
        else
            pending_q <= pending_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_a <= '0;
            data_b <= '0;
        end else if (bus.rd_en && !stall) begin
            data_a <= fwd_a;
            data_b <= fwd_b;
        end
    end

    assign bus.DataA   = data_a;
    assign bus.DataB   = data_b;
    assign bus.stall   = stall;
    assign bus.pending = pending_q;
endmodule
